// File: rtl/plot_fifo.sv
// plot_fifo: buffers pixel plot requests between the draw mux and the VGA adapter; optional clipping via PLOT_FIFO_CLIP_EN
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic [2:0]               colour,
  input  logic                     writeEn,
  input  logic                     out_ready,
  output logic [9:0]               plot_x,
  output logic [9:0]               plot_y,
  output logic [2:0]               plot_colour,
  output logic                     plot,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               overflow_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [22:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          accept, pop, push, drop;
`ifdef PLOT_FIFO_CLIP_EN
  assign accept = writeEn && (x <= 10'(X_MAX)) && (y <= 10'(Y_MAX));
`else
  logic unused_bounds;
  assign unused_bounds = ^{10'(X_MAX), 10'(Y_MAX)};
  assign accept = writeEn;
`endif
  // a push into a full buffer is only allowed when the same edge frees a slot
  always_comb begin
    pop       = out_ready && !empty;
    push      = accept && (!full || pop);
    drop      = accept && full && !pop;
    level_nxt = level + LW'(push) - LW'(pop);
  end
  // storage array; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {x, y, colour};
  end
  // pointers, registered status flags, output register and drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      plot         <= 1'b0;
      plot_x       <= '0;
      plot_y       <= '0;
      plot_colour  <= '0;
      overflow_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      plot   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr                           <= rd_ptr + AW'(1);
        {plot_x, plot_y, plot_colour}    <= mem[rd_ptr];
      end
      plot  <= pop;
      level <= level_nxt;
      full  <= level_nxt == LW'(DEPTH);
      empty <= level_nxt == '0;
      if (drop && overflow_cnt != 8'hff) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_plot_fifo.sv
// tb_plot_fifo: scoreboard bench for plot_fifo
module tb_plot_fifo;
  localparam int DEPTH = 8;
  logic       clk = 1'b0;
  logic       reset, flush, writeEn, out_ready;
  logic [9:0] x, y;
  logic [2:0] colour;
  logic [9:0] plot_x, plot_y;
  logic [2:0] plot_colour;
  logic       plot, full, empty;
  logic [3:0] level;
  logic [7:0] overflow_cnt;
  int         tests = 0;
  int         fails = 0;
  logic [22:0] q[$];
  logic [22:0] mon_e;

  always #5 clk = ~clk;

  plot_fifo #(.DEPTH(DEPTH), .X_MAX(159), .Y_MAX(119)) dut (
    .clk(clk), .reset(reset), .flush(flush), .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .out_ready(out_ready), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .plot(plot), .full(full), .empty(empty),
    .level(level), .overflow_cnt(overflow_cnt)
  );

  // every plotted pixel must be the oldest outstanding expectation
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d, expected no plot", plot_x, plot_y, plot_colour);
      end else begin
        mon_e = q.pop_front();
        if ({plot_x, plot_y, plot_colour} !== mon_e) begin
          fails++;
          $display("FAIL plot_data got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   plot_x, plot_y, plot_colour, mon_e[22:13], mon_e[12:3], mon_e[2:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int px, input int py, input int pc, input bit we, input bit expect_out);
    x       = 10'(px);
    y       = 10'(py);
    colour  = 3'(pc);
    writeEn = we;
    if (expect_out) q.push_back({10'(px), 10'(py), 3'(pc)});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d pixels outstanding, expected 0", name, q.size());
      q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    tests++;
    if ({empty, full, plot, level, overflow_cnt, plot_x, plot_y, plot_colour} !== {1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 23'd0}) begin
      fails++;
      $display("FAIL reset_state got empty=%0b full=%0b plot=%0b level=%0d ovf=%0d x=%0d y=%0d c=%0d, expected 1 0 0 0 0 0 0 0",
               empty, full, plot, level, overflow_cnt, plot_x, plot_y, plot_colour);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(5, 7, 4, 1'b1, 1'b1);
    tick();
    writeEn = 1'b0;
    tests++;
    if (plot !== 1'b0 || level !== 4'd1) begin
      fails++;
      $display("FAIL single_latency1 got plot=%0b level=%0d, expected plot=0 level=1", plot, level);
    end
    tick();
    tests++;
    if ({plot, plot_x, plot_y, plot_colour} !== {1'b1, 10'd5, 10'd7, 3'd4}) begin
      fails++;
      $display("FAIL single_latency2 got plot=%0b x=%0d y=%0d c=%0d, expected plot=1 x=5 y=7 c=4", plot, plot_x, plot_y, plot_colour);
    end
    tick();
    tests++;
    if ({plot, empty, plot_x} !== {1'b0, 1'b1, 10'd5}) begin
      fails++;
      $display("FAIL single_after got plot=%0b empty=%0b x=%0d, expected plot=0 empty=1 x=5", plot, empty, plot_x);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive(i, 20 + i, i % 8, 1'b1, i <= 8);
      tick();
      if (i == 8) begin
        tests++;
        if (full !== 1'b1 || level !== 4'd8) begin
          fails++;
          $display("FAIL overflow_full got full=%0b level=%0d, expected full=1 level=8", full, level);
        end
      end
    end
    writeEn = 1'b0;
    tests++;
    if (overflow_cnt !== 8'd2 || level !== 4'd8) begin
      fails++;
      $display("FAIL overflow_cnt got ovf=%0d level=%0d, expected ovf=2 level=8", overflow_cnt, level);
    end
    out_ready = 1'b1;
    drain("overflow");
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(100 + i, 50 + i, i, 1'b1, 1'b1);
      tick();
    end
    drive(77, 88, 6, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    writeEn = 1'b0;
    tests++;
    if (level !== 4'd8 || full !== 1'b1 || overflow_cnt !== 8'd2) begin
      fails++;
      $display("FAIL full_push_pop got level=%0d full=%0b ovf=%0d, expected level=8 full=1 ovf=2", level, full, overflow_cnt);
    end
    drain("full_push_pop");
    out_ready = 1'b0;
    drive(1, 2, 3, 1'b1, 1'b1);
    tick();
    drive(4, 5, 6, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    writeEn = 1'b0;
    tests++;
    if (level !== 4'd1) begin
      fails++;
      $display("FAIL one_push_pop got level=%0d, expected 1", level);
    end
    drain("one_push_pop");
  endtask

  task automatic test_clip();
    bit clip;
`ifdef PLOT_FIFO_CLIP_EN
    clip = 1'b1;
`else
    clip = 1'b0;
`endif
    out_ready = 1'b1;
    drive(160, 0, 1, 1'b1, !clip);
    tick();
    drive(0, 120, 2, 1'b1, !clip);
    tick();
    drive(159, 119, 3, 1'b1, 1'b1);
    tick();
    writeEn = 1'b0;
    drain("clip");
    tests++;
    if (overflow_cnt !== 8'd2) begin
      fails++;
      $display("FAIL clip_ovf got %0d, expected 2", overflow_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i, i, i, 1'b1, 1'b0);
      tick();
    end
    tests++;
    if (level !== 4'd5) begin
      fails++;
      $display("FAIL flush_pre_level got %0d, expected 5", level);
    end
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(9, 9, 1, 1'b1, 1'b0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (level !== 4'd0 || empty !== 1'b1 || plot !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear got level=%0d empty=%0b plot=%0b, expected 0 1 0", level, empty, plot);
    end
    for (int i = 0; i < 300; i++) begin
      drive(i % 160, i % 120, i % 8, 1'b1, 1'b0);
      tick();
    end
    writeEn = 1'b0;
    tests++;
    if (level !== 4'd8 || full !== 1'b1 || overflow_cnt !== 8'd255) begin
      fails++;
      $display("FAIL flush_saturate got level=%0d full=%0b ovf=%0d, expected 8 1 255", level, full, overflow_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if (level !== 4'd0 || overflow_cnt !== 8'd255) begin
      fails++;
      $display("FAIL flush_keep_ovf got level=%0d ovf=%0d, expected 0 255", level, overflow_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(10 + i, 20 + i, i, 1'b1, 1'b0);
      tick();
    end
    writeEn = 1'b0;
    tests++;
    if (level !== 4'd4) begin
      fails++;
      $display("FAIL reset_mid_pre got level=%0d, expected 4", level);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({empty, plot, level, overflow_cnt} !== {1'b1, 1'b0, 4'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_mid_async got empty=%0b plot=%0b level=%0d ovf=%0d, expected 1 0 0 0", empty, plot, level, overflow_cnt);
    end
    tick();
    reset = 1'b0;
    drive(33, 44, 5, 1'b1, 1'b1);
    tick();
    writeEn = 1'b0;
    tests++;
    if (level !== 4'd1) begin
      fails++;
      $display("FAIL first_push got level=%0d, expected 1", level);
    end
    out_ready = 1'b1;
    drain("reset_mid");
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_empty got %0b, expected 1", empty);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    writeEn   = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    colour    = '0;
    #1;
    test_reset();
    tick();
    tick();
    reset = 1'b0;
    test_single();
    test_overflow();
    test_push_pop();
    test_clip();
    test_flush();
    test_reset_mid();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
